// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: kicks the PLL, waits for a stable lock, then releases staged resets in
// ascending order. Any lock loss re-asserts every reset output and the sequence starts again.
module pll_reset_sequencer #(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned LOCK_STABLE_CYCLES = 256,
  parameter int unsigned LOCK_TIMEOUT       = 65536,
  parameter int unsigned N_RESETS           = 3,
  parameter int unsigned RELEASE_GAP        = 8,
  parameter int unsigned COUNT_W            = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pll_lock_i,
  output logic                pll_rst_o,
  output logic [N_RESETS-1:0] rst_out_o,
  output logic                ready_o,
  output logic [COUNT_W-1:0]  lock_loss_count_o,
  output logic [COUNT_W-1:0]  timeout_count_o
);

  localparam int unsigned RelSpan = (N_RESETS - 1) * RELEASE_GAP;
  localparam int unsigned Max01   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                    PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned Max23   = (LOCK_TIMEOUT > RelSpan) ? LOCK_TIMEOUT : RelSpan;
  localparam int unsigned CntMax  = (Max01 > Max23) ? Max01 : Max23;
  localparam int unsigned CntW    = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] PllLast    = CntW'(PLL_RST_CYCLES - 1);
  localparam logic [CntW-1:0] StableLast = CntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] TmoLast    = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] RelLast    = CntW'(RelSpan);

  typedef enum logic [2:0] {
    StPllReset,
    StWaitLock,
    StStable,
    StRelease,
    StRun
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic [COUNT_W-1:0]     loss_q, loss_d;
  logic [COUNT_W-1:0]     tmo_q, tmo_d;
  logic                   pll_rst_q, pll_rst_d;
  logic [N_RESETS-1:0]    rst_out_q, rst_out_d;
  logic                   ready_q, ready_d;

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock_i};
    end
  end

  // cnt_q is shared: kick length, lock timeout, stable run, or cycles since release start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
    tmo_d   = tmo_q;
    case (state_q)
      StPllReset: begin
        if (cnt_q == PllLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitLock: begin
        if (lock_s) begin
          state_d = StStable;
          cnt_d   = '0;
        end else if (LOCK_TIMEOUT != 0) begin
          if (cnt_q == TmoLast) begin
            state_d = StPllReset;
            cnt_d   = '0;
            if (tmo_q != '1) tmo_d = tmo_q + COUNT_W'(1);
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StStable: begin
        if (!lock_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StRelease;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRelease: begin
        if (!lock_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == RelLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        if (!lock_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
          if (loss_q != '1) loss_d = loss_q + COUNT_W'(1);
        end
      end
      default: begin
        state_d = StPllReset;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    pll_rst_d = (state_d == StPllReset);
    ready_d   = (state_d == StRun);
    rst_out_d = '1;
    for (int unsigned i = 0; i < N_RESETS; i++) begin
      rst_out_d[i] = !((state_d == StRun) ||
                       ((state_d == StRelease) && (cnt_d >= CntW'(i * RELEASE_GAP))));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StPllReset;
      cnt_q     <= '0;
      loss_q    <= '0;
      tmo_q     <= '0;
      pll_rst_q <= 1'b1;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      loss_q    <= loss_d;
      tmo_q     <= tmo_d;
      pll_rst_q <= pll_rst_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
    end
  end

  assign pll_rst_o         = pll_rst_q;
  assign rst_out_o         = rst_out_q;
  assign ready_o           = ready_q;
  assign lock_loss_count_o = loss_q;
  assign timeout_count_o   = tmo_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed phases plus randomized lock waveforms, every cycle
// compared against a mode/elapsed-time reference model.
module tb_pll_reset_sequencer;

  localparam int SyncStages = 2;
  localparam int PllRst     = 4;
  localparam int StableLen  = 8;
  localparam int Timeout    = 32;
  localparam int NRst       = 3;
  localparam int Gap        = 2;
  localparam int CountW     = 4;
  localparam int Sat        = (1 << CountW) - 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              pll_lock = 1'b0;
  logic              pll_rst;
  logic [NRst-1:0]   rst_out;
  logic              ready;
  logic [CountW-1:0] loss_cnt;
  logic [CountW-1:0] tmo_cnt;

  pll_reset_sequencer #(
    .SYNC_STAGES       (SyncStages),
    .PLL_RST_CYCLES    (PllRst),
    .LOCK_STABLE_CYCLES(StableLen),
    .LOCK_TIMEOUT      (Timeout),
    .N_RESETS          (NRst),
    .RELEASE_GAP       (Gap),
    .COUNT_W           (CountW)
  ) u_dut (
    .clock            (clock),
    .reset            (reset),
    .pll_lock_i       (pll_lock),
    .pll_rst_o        (pll_rst),
    .rst_out_o        (rst_out),
    .ready_o          (ready),
    .lock_loss_count_o(loss_cnt),
    .timeout_count_o  (tmo_cnt)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: which phase we are in and how long we have been in it.
  localparam int MKick = 0, MWait = 1, MStable = 2, MRel = 3, MRun = 4;
  int m_mode = MKick;
  int m_el   = 0;
  int m_loss = 0;
  int m_tmo  = 0;
  bit m_hist[SyncStages];

  task automatic model_update();
    bit ls;
    if (reset) begin
      m_mode = MKick;
      m_el   = 0;
      m_loss = 0;
      m_tmo  = 0;
      for (int i = 0; i < SyncStages; i++) m_hist[i] = 1'b0;
    end else begin
      ls = m_hist[SyncStages-1];
      for (int i = SyncStages - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = pll_lock;
      if (m_mode == MKick) begin
        m_el++;
        if (m_el == PllRst) begin m_mode = MWait; m_el = 0; end
      end else if (m_mode == MWait) begin
        if (ls) begin
          m_mode = MStable; m_el = 0;
        end else begin
          m_el++;
          if (Timeout != 0 && m_el == Timeout) begin
            m_mode = MKick; m_el = 0;
            if (m_tmo < Sat) m_tmo++;
          end
        end
      end else if (!ls) begin
        if (m_mode == MRun && m_loss < Sat) m_loss++;
        m_mode = MWait; m_el = 0;
      end else if (m_mode == MStable) begin
        m_el++;
        if (m_el == StableLen) begin m_mode = MRel; m_el = 0; end
      end else if (m_mode == MRel) begin
        if (m_el == (NRst - 1) * Gap) begin m_mode = MRun; m_el = 0; end
        else m_el++;
      end
    end
  endtask

  task automatic compare_all();
    logic [NRst-1:0] e_rst;
    for (int i = 0; i < NRst; i++) begin
      e_rst[i] = !(m_mode == MRun || (m_mode == MRel && m_el >= i * Gap));
    end
    check_eq("pll_rst", 32'(pll_rst), 32'(m_mode == MKick));
    check_eq("rst_out", 32'(rst_out), 32'(e_rst));
    check_eq("ready", 32'(ready), 32'(m_mode == MRun));
    check_eq("loss_cnt", 32'(loss_cnt), 32'(m_loss));
    check_eq("tmo_cnt", 32'(tmo_cnt), 32'(m_tmo));
    check_eq("ready_invariant", 32'(ready && (rst_out != '0 || pll_rst)), 32'(0));
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic hold(input bit lvl, input int cycles);
    pll_lock = lvl;
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    int lat;
    bit seen;

    // Reset with lock already high; ready should rise on the 18th cycle after release.
    reset    = 1'b1;
    pll_lock = 1'b1;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0;
    lat   = 999;
    for (int k = 0; k < 40; k++) begin
      step();
      if (ready && lat == 999) lat = k;
    end
    check_eq("ready_latency", 32'(lat), 32'(17));

    // Lock lost in RUN, then never returns: repeated PLL kicks and timeouts.
    hold(1'b0, 3 * (PllRst + Timeout) + 10);
    check_eq("tmo_after_3", 32'(tmo_cnt), 32'(3));
    check_eq("loss_after_drop", 32'(loss_cnt), 32'(1));

    // Single-cycle glitch while counting stable cycles.
    hold(1'b1, 7);
    hold(1'b0, 1);
    hold(1'b1, 40);

    // Randomized lock waveform: long highs, short glitches and occasional long outages.
    for (int s = 0; s < 60; s++) begin
      hold(1'b1, $urandom_range(1, 60));
      if ($urandom_range(0, 9) < 7) hold(1'b0, $urandom_range(1, 3));
      else hold(1'b0, $urandom_range(30, 45));
    end

    // Twenty losses from RUN saturate the loss counter.
    for (int n = 0; n < 20; n++) begin
      hold(1'b1, 30);
      hold(1'b0, 2);
    end
    check_eq("loss_sat", 32'(loss_cnt), 32'(Sat));

    // Reset asserted mid-release.
    pll_lock = 1'b1;
    seen     = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      step();
      if (rst_out == 3'b100) seen = 1'b1;
    end
    check_eq("reach_rel_100", 32'(seen), 32'(1));
    reset = 1'b1;
    step();
    check_eq("rst_rst_out", 32'(rst_out), 32'(3'b111));
    check_eq("rst_pll_rst", 32'(pll_rst), 32'(1));
    check_eq("rst_counts", 32'({loss_cnt, tmo_cnt}), 32'(0));
    reset = 1'b0;
    hold(1'b1, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
